uart_pkt_tx: RTL and testbench



---
 rtl/uart_pkt_tx_pkg.sv | 25 ++
 rtl/pkt_sync_fifo.sv | 57 +++++
 rtl/uart_pkt_tx.sv | 128 ++++++++++++
 tb/tb_uart_pkt_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_tx_pkg.sv
// Shared packet framing definitions: FSM encoding, default header bytes, checksum width.
// No logic; compile-time constants only. Also intended for the receive-side parser.
// No flow control here.
package uart_pkt_tx_pkg;

    localparam logic [7:0] HDR0_DEFAULT = 8'h55;
    localparam logic [7:0] HDR1_DEFAULT = 8'hAA;
    localparam int         CHK_W        = 8;

    typedef logic [CHK_W-1:0] chk_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_WAIT_HI,
        ST_WAIT_LO
    } tx_state_t;

    // Modulo-256 running sum; carries out of the top bit are discarded.
    function automatic chk_t chk_add(input chk_t acc, input logic [7:0] b);
        return acc + chk_t'(b);
    endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Single-clock byte FIFO with occupancy count and full/empty flags.
// Read data registered: valid the cycle after rd_en. Count/flags update the cycle after an access.
// Writes while full are dropped; reads while empty are ignored.
module pkt_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            count <= count + CW'(wr_ok) - CW'(rd_ok);
        end
    end

endmodule

// File: rtl/uart_pkt_tx.sv
// Frames buffered payload bytes as HDR0, HDR1, LEN, payload, CHK and feeds them to uart_tx.
// pkt_busy one cycle after pkt_send; first byte strobe two cycles after pkt_send when uart_tx idle.
// Each byte waits for uart_tx_busy low, then a busy high/low cycle; writes dropped while full.
module uart_pkt_tx
    import uart_pkt_tx_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] HDR0       = HDR0_DEFAULT,
    parameter logic [7:0] HDR1       = HDR1_DEFAULT
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       pkt_send,
    output logic       full,
    output logic       pkt_busy,
    input  logic       uart_tx_busy,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             fifo_rd_en;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;
    logic [CNT_W-1:0] fifo_count;

    tx_state_t  state;
    logic [7:0] len;
    logic [7:0] idx;
    chk_t       chk;
    logic       last_byte;
    logic       payload_next;

    pkt_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd_en),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (full),
        .empty   (fifo_empty)
    );

    // Frame position: 0/1 header, 2 LEN, 3..LEN+2 payload, LEN+3 checksum.
    assign last_byte    = (idx == len + 8'd3);
    assign payload_next = (idx >= 8'd2) && (idx <= len + 8'd1);
    // Payload read is issued on the way into LOAD so the byte is ready there.
    assign fifo_rd_en   = (state == ST_WAIT_LO) && !uart_tx_busy && payload_next;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            len          <= '0;
            idx          <= '0;
            chk          <= '0;
            pkt_busy     <= 1'b0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pkt_send && !fifo_empty) begin
                        len      <= 8'(fifo_count);
                        chk      <= '0;
                        idx      <= '0;
                        pkt_busy <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (idx == 8'd0) begin
                        uart_tx_data <= HDR0;
                    end else if (idx == 8'd1) begin
                        uart_tx_data <= HDR1;
                    end else if (idx == 8'd2) begin
                        uart_tx_data <= len;
                        chk          <= chk_add(chk, len);
                    end else if (last_byte) begin
                        uart_tx_data <= chk;
                    end else begin
                        uart_tx_data <= fifo_rd_data;
                        chk          <= chk_add(chk, fifo_rd_data);
                    end
                    // Registered strobe looks one cycle ahead so it lands in the first LAUNCH cycle.
                    uart_tx_en <= !uart_tx_busy;
                    state      <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    if (uart_tx_en) begin
                        uart_tx_en <= 1'b0;
                        state      <= ST_WAIT_HI;
                    end else begin
                        uart_tx_en <= !uart_tx_busy;
                    end
                end
                ST_WAIT_HI: begin
                    if (uart_tx_busy) begin
                        state <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!uart_tx_busy) begin
                        if (last_byte) begin
                            pkt_busy <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    uart_tx_en <= 1'b0;
                    pkt_busy   <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_tx.sv
// Directed plus randomized bench for uart_pkt_tx with a behavioural uart_tx responder
// and a queue-based frame reference model.
module tb_uart_pkt_tx;
    localparam int DEPTH = 16;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       pkt_send;
    logic       full;
    logic       pkt_busy;
    logic       uart_tx_busy;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;

    int         checks;
    int         errors;
    int         pulses;
    int         busy_cnt;
    bit         hold;
    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    uart_pkt_tx #(
        .FIFO_DEPTH (DEPTH),
        .HDR0       (8'h55),
        .HDR1       (8'hAA)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .pkt_send     (pkt_send),
        .full         (full),
        .pkt_busy     (pkt_busy),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // uart_tx stand-in: captures each strobed byte, then stays busy a random frame time.
    initial begin
        uart_tx_busy = 1'b0;
        busy_cnt     = 0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!sys_rst_n) begin
                busy_cnt = 0;
            end else if (uart_tx_en === 1'b1) begin
                chk("en_while_busy", uart_tx_busy, 0);
                got_q.push_back(uart_tx_data);
                pulses++;
                busy_cnt = $urandom_range(2, 10);
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            uart_tx_busy = hold || (busy_cnt > 0);
        end
    end

    task automatic push_model(input logic [7:0] b);
        if (pay_q.size() < DEPTH) pay_q.push_back(b);
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        push_model(b);
        @(negedge sys_clk);
        wr_en = 1'b0;
    endtask

    // Expected frame from the buffered payload: header, length, bytes, (length + sum) mod 256.
    task automatic model_frame();
        int len;
        int sum;
        logic [7:0] b;
        len = pay_q.size();
        if (len == 0) return;
        sum = len;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        exp_q.push_back(len[7:0]);
        for (int i = 0; i < len; i++) begin
            b = pay_q.pop_front();
            sum = sum + int'(b);
            exp_q.push_back(b);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic send(input bit with_wr, input logic [7:0] b);
        pkt_send = 1'b1;
        model_frame();
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_data = b;
            push_model(b);
        end
        @(negedge sys_clk);
        pkt_send = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic pulse_send_raw();
        pkt_send = 1'b1;
        @(negedge sys_clk);
        pkt_send = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (pkt_busy === 1'b1 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk("idle_timeout", pkt_busy, 0);
    endtask

    task automatic wait_bytes(input int nb, input int budget);
        int n;
        n = 0;
        while (got_q.size() < nb && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk("bytes_timeout", (got_q.size() >= nb), 1);
    endtask

    task automatic check_frame(input string tag);
        wait_idle(4000);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int p;
        int n;
        checks    = 0;
        errors    = 0;
        pulses    = 0;
        hold      = 1'b0;
        sys_rst_n = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        pkt_send  = 1'b0;

        repeat (3) @(negedge sys_clk);
        chk("rst_en", uart_tx_en, 0);
        chk("rst_data", uart_tx_data, 8'h00);
        chk("rst_full", full, 0);
        chk("rst_busy", pkt_busy, 0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);

        // Basic three-byte packet with launch timing.
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        send(1'b0, 8'h00);
        chk("t1_busy", pkt_busy, 1);
        chk("t1_en", uart_tx_en, 0);
        @(negedge sys_clk);
        chk("t2_en", uart_tx_en, 1);
        chk("t2_hdr0", uart_tx_data, 8'h55);
        check_frame("basic");
        chk("basic_done_busy", pkt_busy, 0);

        // Fill to capacity, overflow write dropped.
        for (int i = 0; i < DEPTH - 1; i++) write_byte(8'hFF);
        chk("full_at_15", full, 0);
        write_byte(8'hFF);
        chk("full_at_16", full, 1);
        write_byte(8'hFF);
        chk("full_after_drop", full, 1);
        send(1'b0, 8'h00);
        check_frame("full");
        chk("full_drained", full, 0);

        // Send with empty buffer is ignored.
        p = pulses;
        pulse_send_raw();
        chk("empty_busy_t1", pkt_busy, 0);
        repeat (20) @(negedge sys_clk);
        chk("empty_busy", pkt_busy, 0);
        chk("empty_pulses", pulses, p);

        // Same-cycle write lands in the next packet; mid-packet send ignored.
        write_byte(8'h11);
        write_byte(8'h22);
        send(1'b1, 8'hA5);
        wait_bytes(4, 500);
        pulse_send_raw();
        check_frame("sameclk");
        send(1'b0, 8'h00);
        check_frame("next_pkt");

        // uart_tx held busy before the first byte.
        hold = 1'b1;
        repeat (2) @(negedge sys_clk);
        write_byte(8'h5C);
        p = pulses;
        send(1'b0, 8'h00);
        repeat (500) @(negedge sys_clk);
        chk("hold_no_pulse", pulses, p);
        chk("hold_busy", pkt_busy, 1);
        hold = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("hold_one_pulse", pulses, p + 1);
        check_frame("hold");

        // Randomized packets.
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < n; i++) write_byte(8'($urandom_range(0, 255)));
            send(1'b0, 8'h00);
            check_frame($sformatf("rand%0d", k));
        end

        // Reset mid-payload abandons the packet.
        for (int i = 0; i < 8; i++) write_byte(8'($urandom_range(0, 255)));
        send(1'b0, 8'h00);
        wait_bytes(5, 500);
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_en", uart_tx_en, 0);
        chk("mid_rst_data", uart_tx_data, 8'h00);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_busy", pkt_busy, 0);
        pay_q.delete();
        exp_q.delete();
        got_q.delete();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        got_q.delete();
        write_byte(8'h7E);
        send(1'b0, 8'h00);
        check_frame("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
